// File: rtl/spi_slave_datapath_pkg.sv
// Shared definitions for the SPI slave datapath, its controller and benches.
//   SPI_DATA_WIDTH / SPI_SYNC_STAGES : default word length and synchroniser depth
//   spi_mode_e                       : SPI mode encoding as {CPOL,CPHA}
//   mode_cpol / mode_cpha            : split a mode into its clock polarity/phase
package spi_slave_datapath_pkg;

  localparam int unsigned SPI_DATA_WIDTH  = 8;
  localparam int unsigned SPI_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    SPI_MODE0 = 2'b00,
    SPI_MODE1 = 2'b01,
    SPI_MODE2 = 2'b10,
    SPI_MODE3 = 2'b11
  } spi_mode_e;

  function automatic logic mode_cpol(input spi_mode_e mode);
    logic [1:0] bits;
    bits = mode;
    return bits[1];
  endfunction

  function automatic logic mode_cpha(input spi_mode_e mode);
    logic [1:0] bits;
    bits = mode;
    return bits[0];
  endfunction

endpackage

// File: rtl/spi_slave_datapath_sync_edge.sv
// spi_sync_edge: multi-flop synchroniser with one extra delayed copy for
// edge detection.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   d_i           : raw asynchronous input
//   level_o       : synchronised level
//   rise_o/fall_o : one-cycle strobes when level_o changes 0->1 / 1->0
module spi_sync_edge #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level_o = sync_q[STAGES-1];
  assign rise_o  = level_o & ~prev_q;
  assign fall_o  = ~level_o & prev_q;

endmodule

// File: rtl/spi_slave_datapath.sv
// spi_slave_datapath: SPI slave front-end and MSB-first shift datapath.
// Synchronises SCLK/SS/MOSI, produces edge strobes, and executes the
// controller's load / shift commands on the TX and RX shift registers.
//   i_clk, i_reset          : system clock, asynchronous active-low reset
//   i_sclk, i_ss_n, i_mosi  : raw SPI pins
//   i_CPOL, i_CPHA          : SPI mode (static while selected)
//   i_load_register         : load TX from i_tx_data
//   i_shift_enable          : allow sample/drive events
//   i_tx_data, i_tx_valid   : head of TX FIFO
//   o_miso                  : TX MSB (1 while deselected)
//   o_SS                    : synchronised slave select
//   o_leading, o_trailing   : SCLK edge strobes
//   o_tx_ack, o_tx_underrun : TX word consumed / word boundary with no data
//   o_rx_data, o_DV         : last received word and its update strobe
module spi_slave_datapath
  import spi_slave_datapath_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = SPI_DATA_WIDTH,
  parameter int unsigned SYNC_STAGES = SPI_SYNC_STAGES
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_sclk,
  input  logic                  i_ss_n,
  input  logic                  i_mosi,
  input  logic                  i_CPOL,
  input  logic                  i_CPHA,
  input  logic                  i_load_register,
  input  logic                  i_shift_enable,
  input  logic [DATA_WIDTH-1:0] i_tx_data,
  input  logic                  i_tx_valid,
  output logic                  o_miso,
  output logic                  o_SS,
  output logic                  o_leading,
  output logic                  o_trailing,
  output logic                  o_tx_ack,
  output logic                  o_tx_underrun,
  output logic [DATA_WIDTH-1:0] o_rx_data,
  output logic                  o_DV
);

  localparam int unsigned          CNT_W    = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0]     LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic ss_lvl, ss_rise, ss_fall;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic mosi_s;

  logic [DATA_WIDTH-1:0] tx_q, tx_d, rx_q, rx_d, rx_data_q, rx_data_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  dv_q, dv_d, ack_q, ack_d, unr_q, unr_d;
  logic                  ss_ok, sclk_edge, sample_ev, drive_ev;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
    .clk_i(i_clk), .rst_ni(i_reset), .d_i(i_sclk),
    .level_o(sclk_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_ss_sync (
    .clk_i(i_clk), .rst_ni(i_reset), .d_i(i_ss_n),
    .level_o(ss_lvl), .rise_o(ss_rise), .fall_o(ss_fall)
  );

  // MOSI has the same depth as the SCLK level so data and edge line up.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) mosi_sync_q <= '0;
    else          mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], i_mosi};
  end
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  // Selected now and last cycle: the SS-assert cycle (ss_fall) is excluded.
  assign ss_ok      = ~ss_lvl & ~ss_fall;
  assign sclk_edge  = ss_ok & (sclk_rise | sclk_fall);
  // Leading edge moves SCLK away from its idle level CPOL.
  assign o_leading  = sclk_edge & (sclk_lvl ^ i_CPOL);
  assign o_trailing = sclk_edge & ~(sclk_lvl ^ i_CPOL);
  assign sample_ev  = i_shift_enable & (i_CPHA ? o_trailing : o_leading);
  assign drive_ev   = i_shift_enable & (i_CPHA ? o_leading : o_trailing) & (cnt_q != '0);

  always_comb begin
    tx_d      = tx_q;
    rx_d      = rx_q;
    cnt_d     = cnt_q;
    rx_data_d = rx_data_q;
    dv_d      = 1'b0;
    ack_d     = 1'b0;
    unr_d     = 1'b0;
    if (ss_rise) begin
      tx_d  = '1;
      rx_d  = '0;
      cnt_d = '0;
    end else begin
      if (sample_ev) begin
        rx_d = {rx_q[DATA_WIDTH-2:0], mosi_s};
        if (cnt_q == LAST_BIT) begin
          rx_data_d = rx_d;
          dv_d      = 1'b1;
          cnt_d     = '0;
          if (i_tx_valid) begin
            tx_d  = i_tx_data;
            ack_d = 1'b1;
          end else begin
            tx_d  = '1;
            unr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      if (drive_ev) tx_d = {tx_q[DATA_WIDTH-2:0], 1'b1};
      // An explicit load overrides any boundary reload; only one ack results.
      if (i_load_register) begin
        tx_d  = i_tx_data;
        ack_d = 1'b1;
        unr_d = 1'b0;
        cnt_d = '0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      tx_q      <= '1;
      rx_q      <= '0;
      cnt_q     <= '0;
      rx_data_q <= '0;
      dv_q      <= 1'b0;
      ack_q     <= 1'b0;
      unr_q     <= 1'b0;
    end else begin
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      cnt_q     <= cnt_d;
      rx_data_q <= rx_data_d;
      dv_q      <= dv_d;
      ack_q     <= ack_d;
      unr_q     <= unr_d;
    end
  end

  assign o_SS          = ss_lvl;
  assign o_miso        = ss_lvl | tx_q[DATA_WIDTH-1];
  assign o_rx_data     = rx_data_q;
  assign o_DV          = dv_q;
  assign o_tx_ack      = ack_q;
  assign o_tx_underrun = unr_q;

endmodule

// File: tb/tb_spi_slave_datapath.sv
// Bench for spi_slave_datapath: an SPI master model drives the pins, a TX
// FIFO model feeds i_tx_data, and received words are checked by a scoreboard
// popped on every o_DV.
module tb_spi_slave_datapath;
  import spi_slave_datapath_pkg::*;

  localparam int unsigned DW   = 8;
  localparam int unsigned SS_N = 2;
  localparam int          H    = 8;

  logic clk = 1'b0, rst_n = 1'b0;
  logic sclk = 1'b0, ss_n = 1'b1, mosi = 1'b0;
  logic cpol = 1'b0, cpha = 1'b0, load = 1'b0, shen = 1'b1;
  logic [DW-1:0] tx_data = '0;
  logic tx_valid = 1'b0;
  logic o_miso, o_SS, o_leading, o_trailing, o_tx_ack, o_tx_underrun, o_DV;
  logic [DW-1:0] o_rx_data;

  always #5 clk = ~clk;

  spi_slave_datapath #(.DATA_WIDTH(DW), .SYNC_STAGES(SS_N)) dut (
    .i_clk(clk), .i_reset(rst_n), .i_sclk(sclk), .i_ss_n(ss_n), .i_mosi(mosi),
    .i_CPOL(cpol), .i_CPHA(cpha), .i_load_register(load), .i_shift_enable(shen),
    .i_tx_data(tx_data), .i_tx_valid(tx_valid), .o_miso(o_miso), .o_SS(o_SS),
    .o_leading(o_leading), .o_trailing(o_trailing), .o_tx_ack(o_tx_ack),
    .o_tx_underrun(o_tx_underrun), .o_rx_data(o_rx_data), .o_DV(o_DV)
  );

  int errors = 0, checks = 0;
  logic [DW-1:0] rx_exp[$];
  logic [DW-1:0] tx_mem[64];
  int tx_wr = 0, tx_rd = 0;
  int ack_cnt = 0, unr_cnt = 0, strobe_cnt = 0;
  logic [DW-1:0] mo[4], tw[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_ss(input logic v);
    int t;
    t = 0;
    while (o_SS !== v && t < 10) begin
      @(negedge clk);
      t++;
    end
    check("ss_sync", o_SS, v);
  endtask

  // Master side of nbits bit-times; collects what it sees on MISO.
  task automatic shift_bits(input logic [DW-1:0] w, input int nbits, output logic [DW-1:0] mi);
    mi = '0;
    for (int i = 0; i < nbits; i++) begin
      if (!cpha) begin
        mosi = w[DW-1-i];
        wait_cyc(H);
        mi = {mi[DW-2:0], o_miso};
        sclk = ~cpol;
        wait_cyc(H);
        sclk = cpol;
      end else begin
        sclk = ~cpol;
        mosi = w[DW-1-i];
        wait_cyc(H);
        mi = {mi[DW-2:0], o_miso};
        sclk = cpol;
        wait_cyc(H);
      end
    end
  endtask

  // One selected transfer of n words (last one cut to 'partial' bits if >0),
  // with ntx words offered by the TX FIFO.
  task automatic run_xfer(input string tag, input spi_mode_e mode, input int n,
                          input int partial, input int ntx);
    int a0, u0, attempts, full, exp_ack;
    logic [DW-1:0] mi;
    a0 = ack_cnt;
    u0 = unr_cnt;
    for (int k = 0; k < ntx; k++) begin
      tx_mem[tx_wr[5:0]] = tw[k];
      tx_wr++;
    end
    cpol = mode_cpol(mode);
    cpha = mode_cpha(mode);
    sclk = cpol;
    wait_cyc(4);
    ss_n = 1'b0;
    wait_ss(1'b0);
    wait_cyc(1);
    load = 1'b1;
    wait_cyc(1);
    load = 1'b0;
    wait_cyc(3);
    full = 0;
    for (int w = 0; w < n; w++) begin
      int nb;
      nb = (partial > 0 && w == n - 1) ? partial : DW;
      if (nb == DW) rx_exp.push_back(mo[w]);
      shift_bits(mo[w], nb, mi);
      if (nb == DW) begin
        check({tag, " miso"}, mi, (w < ntx) ? tw[w] : 8'hFF);
        full++;
      end
    end
    wait_cyc(H);
    ss_n = 1'b1;
    wait_ss(1'b1);
    wait_cyc(4);
    check({tag, " miso_idle"}, o_miso, 1'b1);
    attempts = 1 + full;
    exp_ack  = (attempts < ntx) ? attempts : ntx;
    check({tag, " tx_acks"}, ack_cnt - a0, exp_ack);
    check({tag, " underruns"}, unr_cnt - u0, attempts - exp_ack);
    check({tag, " rx_pending"}, rx_exp.size(), 0);
  endtask

  initial begin
    int s0, c, a0;
    logic [DW-1:0] mi;
    fork
      begin : monitor
        logic [DW-1:0] e;
        forever begin
          @(negedge clk);
          if (o_DV) begin
            if (rx_exp.size() == 0) check("unexpected_dv", o_DV, 1'b0);
            else begin
              e = rx_exp.pop_front();
              check("rx_data", o_rx_data, e);
            end
          end
          if (o_tx_ack) begin
            ack_cnt++;
            tx_rd++;
          end
          if (o_tx_underrun) unr_cnt++;
          if (o_leading | o_trailing) strobe_cnt++;
          tx_valid = (tx_rd < tx_wr);
          tx_data  = tx_valid ? tx_mem[tx_rd[5:0]] : '0;
        end
      end
      begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
      end
    join_none

    // Reset state
    wait_cyc(3);
    check("rst o_SS", o_SS, 1'b1);
    check("rst o_miso", o_miso, 1'b1);
    check("rst o_rx_data", o_rx_data, 0);
    check("rst pulses", {o_DV, o_tx_ack, o_tx_underrun, o_leading, o_trailing}, 0);
    rst_n = 1'b1;
    wait_cyc(4);

    mo = '{8'h3C, 8'h00, 8'h00, 8'h00};
    tw = '{8'hA5, 8'h00, 8'h00, 8'h00};
    run_xfer("mode0", SPI_MODE0, 1, 0, 1);

    mo = '{8'h12, 8'h34, 8'h00, 8'h00};
    tw = '{8'h81, 8'h7E, 8'h00, 8'h00};
    run_xfer("mode3_b2b", SPI_MODE3, 2, 0, 2);

    mo = '{8'hAA, 8'h55, 8'h00, 8'h00};
    tw = '{8'hC3, 8'h00, 8'h00, 8'h00};
    run_xfer("mode1_underrun", SPI_MODE1, 2, 0, 1);

    mo = '{8'hF0, 8'h00, 8'h00, 8'h00};
    tw = '{8'h5A, 8'h00, 8'h00, 8'h00};
    run_xfer("mode2_partial", SPI_MODE2, 1, 5, 1);
    mo = '{8'h69, 8'h00, 8'h00, 8'h00};
    tw = '{8'h96, 8'h00, 8'h00, 8'h00};
    run_xfer("mode2_after_abort", SPI_MODE2, 1, 0, 1);

    // Reset in the middle of a mode-0 word
    tx_mem[tx_wr[5:0]] = 8'h33;
    tx_wr++;
    cpol = 1'b0;
    cpha = 1'b0;
    sclk = 1'b0;
    wait_cyc(4);
    ss_n = 1'b0;
    wait_ss(1'b0);
    wait_cyc(1);
    load = 1'b1;
    wait_cyc(1);
    load = 1'b0;
    wait_cyc(3);
    shift_bits(8'hE7, 3, mi);
    wait_cyc(2);
    rst_n = 1'b0;
    #1;
    check("midrst o_SS", o_SS, 1'b1);
    check("midrst o_miso", o_miso, 1'b1);
    check("midrst o_rx_data", o_rx_data, 0);
    check("midrst pulses", {o_DV, o_tx_ack, o_tx_underrun, o_leading, o_trailing}, 0);
    ss_n = 1'b1;
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(4);
    mo = '{8'h55, 8'h00, 8'h00, 8'h00};
    tw = '{8'hCC, 8'h00, 8'h00, 8'h00};
    run_xfer("post_reset", SPI_MODE0, 1, 0, 1);

    // CPOL=1 with SCLK idling high: select must not look like an edge
    shen = 1'b0;
    cpol = 1'b1;
    cpha = 1'b1;
    sclk = 1'b1;
    wait_cyc(6);
    s0 = strobe_cnt;
    a0 = ack_cnt;
    ss_n = 1'b0;
    wait_ss(1'b0);
    wait_cyc(8);
    check("no_spurious_strobe", strobe_cnt - s0, 0);
    sclk = 1'b0;
    c = 0;
    while (!o_leading && c < 10) begin
      @(negedge clk);
      c++;
    end
    check("leading_latency", c, SS_N);
    check("leading_seen", o_leading, 1'b1);
    wait_cyc(H);
    sclk = 1'b1;
    wait_cyc(H);
    check("strobes_without_shift", strobe_cnt - s0, 2);
    ss_n = 1'b1;
    wait_ss(1'b1);
    wait_cyc(4);
    check("no_ack_without_shift", ack_cnt - a0, 0);
    check("no_dv_without_shift", rx_exp.size(), 0);
    shen = 1'b1;

    // Randomised transfers
    for (int r = 0; r < 4; r++) begin
      spi_mode_e m;
      int n, ntx;
      m   = spi_mode_e'(2'($urandom_range(0, 3)));
      n   = $urandom_range(1, 3);
      ntx = $urandom_range(1, n + 1);
      for (int k = 0; k < 4; k++) begin
        mo[k] = 8'($urandom);
        tw[k] = 8'($urandom);
      end
      run_xfer("random", m, n, 0, ntx);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
